// File: rtl/hex_scan_pkg.sv
// rtl/hex_scan_pkg.sv - shared constants and scan state type for the hex scan driver.
package hex_scan_pkg;
  localparam int         NUM_DIGITS = 8;
  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam logic [6:0] SEG_ZERO   = 7'b1000000;

  typedef enum logic [1:0] {OFF, BLANK, DRIVE} scan_state_e;
endpackage

// File: rtl/hex_scan_timer.sv
// rtl/hex_scan_timer.sv - slot counter, digit index and scan state; exposes next-cycle position
// so the top can register its outputs in step with the counters.
module hex_scan_timer
  import hex_scan_pkg::*;
#(
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  output logic [2:0] d_nxt,
  output logic       drive_nxt,
  output logic       frame_bnd,
  output logic       frame_done
);
  localparam int            CW      = $clog2(PRESCALE);
  localparam logic [CW-1:0] C_LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] C_DRIVE = CW'(BLANK_CYCLES);

  logic [CW-1:0] c_q, c_d;
  logic [2:0]    d_q, d_d;
  scan_state_e   state_q, state_d;
  logic          frame_done_q;

  always_comb begin
    c_d     = c_q + 1'b1;
    d_d     = d_q;
    state_d = state_q;
    if (!enable) begin
      c_d     = '0;
      d_d     = '0;
      state_d = OFF;
    end else if (state_q == OFF) begin
      c_d     = '0;
      d_d     = '0;
      state_d = BLANK;
    end else if (c_q == C_LAST) begin
      c_d     = '0;
      d_d     = d_q + 3'd1;
      state_d = BLANK;
    end else if (c_d == C_DRIVE) begin
      state_d = DRIVE;
    end
  end

  // Blanking is at least one cycle, so the last cycle of digit 7 is always a DRIVE cycle.
  assign frame_bnd = enable && (state_q == DRIVE) && (d_q == 3'd7) && (c_q == C_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      c_q          <= '0;
      d_q          <= '0;
      state_q      <= OFF;
      frame_done_q <= 1'b0;
    end else begin
      c_q          <= c_d;
      d_q          <= d_d;
      state_q      <= state_d;
      frame_done_q <= frame_bnd;
    end
  end

  assign d_nxt      = d_d;
  assign drive_nxt  = (state_d == DRIVE);
  assign frame_done = frame_done_q;
endmodule

// File: rtl/hex_scan_driver.sv
// rtl/hex_scan_driver.sv - shadow bank, snapshot handshake and registered scan outputs.
// Define HEX_SCAN_LZB_EN for leading-zero blanking of the upper digits.
module hex_scan_driver
  import hex_scan_pkg::*;
#(
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       load,
  input  logic [6:0] seg0,
  input  logic [6:0] seg1,
  input  logic [6:0] seg2,
  input  logic [6:0] seg3,
  input  logic [6:0] seg4,
  input  logic [6:0] seg5,
  input  logic [6:0] seg6,
  input  logic [6:0] seg7,
  output logic [6:0] seg_out,
  output logic [7:0] dig_out,
  output logic       load_ack,
  output logic       frame_done
);
  logic [6:0] seg_in   [NUM_DIGITS];
  logic [6:0] shadow_q [NUM_DIGITS];
  logic [6:0] shadow_d [NUM_DIGITS];
  logic       pending_q, pending_d;
  logic       load_ack_q, load_ack_d;
  logic [6:0] seg_out_q, seg_out_d;
  logic [7:0] dig_out_q, dig_out_d;
  logic [2:0] d_nxt;
  logic       drive_nxt;
  logic       frame_bnd;

  assign seg_in[0] = seg0;
  assign seg_in[1] = seg1;
  assign seg_in[2] = seg2;
  assign seg_in[3] = seg3;
  assign seg_in[4] = seg4;
  assign seg_in[5] = seg5;
  assign seg_in[6] = seg6;
  assign seg_in[7] = seg7;

  hex_scan_timer #(
    .PRESCALE     (PRESCALE),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .d_nxt      (d_nxt),
    .drive_nxt  (drive_nxt),
    .frame_bnd  (frame_bnd),
    .frame_done (frame_done)
  );

`ifdef HEX_SCAN_LZB_EN
  logic [NUM_DIGITS-1:0] lzb_mask;
  logic                  lz_run;

  // Digit 0 is left out of the walk so it always shows its pattern.
  always_comb begin
    lzb_mask = '0;
    lz_run   = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      lz_run      = lz_run && (shadow_q[i] == SEG_ZERO);
      lzb_mask[i] = lz_run;
    end
  end
`endif

  always_comb begin
    pending_d  = pending_q | load;
    shadow_d   = shadow_q;
    load_ack_d = 1'b0;
    // While disabled every edge is a boundary, so a pending load is taken at once.
    if ((frame_bnd || !enable) && pending_d) begin
      shadow_d   = seg_in;
      pending_d  = 1'b0;
      load_ack_d = 1'b1;
    end
    seg_out_d = SEG_BLANK;
    dig_out_d = 8'hFF;
    if (drive_nxt) begin
      dig_out_d = ~(8'd1 << d_nxt);
`ifdef HEX_SCAN_LZB_EN
      seg_out_d = lzb_mask[d_nxt] ? SEG_BLANK : shadow_q[d_nxt];
`else
      seg_out_d = shadow_q[d_nxt];
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow_q   <= '{default: SEG_BLANK};
      pending_q  <= 1'b0;
      load_ack_q <= 1'b0;
      seg_out_q  <= SEG_BLANK;
      dig_out_q  <= 8'hFF;
    end else begin
      shadow_q   <= shadow_d;
      pending_q  <= pending_d;
      load_ack_q <= load_ack_d;
      seg_out_q  <= seg_out_d;
      dig_out_q  <= dig_out_d;
    end
  end

  assign seg_out  = seg_out_q;
  assign dig_out  = dig_out_q;
  assign load_ack = load_ack_q;
endmodule
